// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a binary position (run at div+1 clocks or one per step) and emits its Gray code
// Ports: clk/rst (async active-high); start/stop/step command pulses; dir (0 up, 1 down);
//   div prescaler latched at start; bin/gray registered position and code; running in RUN; wrap on roll-over.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             running,
  output logic             wrap
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d;
  logic [WIDTH-1:0]   bin_q, bin_d, gray_q, gray_d;
  logic               wrap_q, wrap_d, adv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end
  always_comb begin
    state_d = stop ? IDLE : start ? RUN : state_q;
  end
  // stop and start both suppress the advance on their edge; step only counts while IDLE
  always_comb begin
    adv    = !stop && !start && ((state_q == RUN) ? (cnt_q == div_q) : step);
    cnt_d  = (stop || start || adv || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    div_d  = (!stop && start) ? div : div_q;
    bin_d  = adv ? (dir ? bin_q - 1'b1 : bin_q + 1'b1) : bin_q;
    gray_d = bin_d ^ (bin_d >> 1);
    wrap_d = adv && (dir ? (bin_q == '0) : (bin_q == {WIDTH{1'b1}}));
  end
  assign bin     = bin_q;
  assign gray    = gray_q;
  assign running = (state_q == RUN);
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: random and directed checks of gray_seq_ctrl against a countdown-based model
module tb_gray_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
  logic [23:0] div = '0;
  logic [3:0]  bin, gray;
  logic        running, wrap;
  int tests = 0, fails = 0;
  int mbin = 0, mrun = 0, mwrap = 0, mleft = 0, mperiod = 0, madv = 0;
  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  logic [3:0] prev_gray = '0;

  gray_seq_ctrl #(.WIDTH(4), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
    .div(div), .bin(bin), .gray(gray), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbin = 0; mrun = 0; mwrap = 0; mleft = 0; mperiod = 0; madv = 0;
    end else begin
      madv = 0;
      if (stop) mrun = 0;
      else if (start) begin
        mrun = 1; mperiod = int'(div) + 1; mleft = mperiod;
      end else if (mrun != 0) begin
        mleft = mleft - 1;
        if (mleft == 0) begin madv = 1; mleft = mperiod; end
      end else if (step) madv = 1;
      mwrap = 0;
      if (madv != 0) begin
        if (dir) begin mwrap = (mbin == 0); mbin = (mbin + 15) % 16; end
        else begin mwrap = (mbin == 15); mbin = (mbin + 1) % 16; end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("bin", int'(bin), mbin);
    chk("gray", int'(gray), gray_tab[mbin]);
    chk("running", int'(running), mrun);
    chk("wrap", int'(wrap), mwrap);
    if (madv != 0 && !rst) chk("gray_one_bit", $countones(gray ^ prev_gray), 1);
    prev_gray = gray;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_step;
    step = 1'b1; tick; step = 1'b0;
  endtask

  initial begin
    tick; tick;
    rst = 1'b0;
    chk("reset_bin", int'(bin), 0);
    chk("reset_run", int'(running), 0);
    for (int i = 1; i <= 16; i++) begin
      pulse_step;
      chk("step_up_bin", int'(bin), i % 16);
      chk("step_up_wrap", int'(wrap), (i == 16) ? 1 : 0);
      if (i == 2) chk("gray_at_2", int'(gray), 4'b0011);
      if (i == 8) chk("gray_at_8", int'(gray), 4'b1100);
      if (i == 16) chk("gray_at_16", int'(gray), 0);
    end
    tick;
    chk("wrap_one_cycle", int'(wrap), 0);
    dir = 1'b1;
    pulse_step;
    chk("down_bin", int'(bin), 15);
    chk("down_gray", int'(gray), 4'b1000);
    chk("down_wrap", int'(wrap), 1);
    dir = 1'b0; div = 24'd3; start = 1'b1;
    tick;
    start = 1'b0; div = 24'd0;
    chk("run_started", int'(running), 1);
    for (int k = 1; k <= 15; k++) begin
      tick;
      chk("run_bin", int'(bin), (15 + k / 4) % 16);
      chk("run_wrap", int'(wrap), (k == 4) ? 1 : 0);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_no_adv", int'(bin), 2);
    chk("stop_idle", int'(running), 0);
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", int'(running), 0);
    chk("start_stop_bin", int'(bin), 2);
    div = 24'd2; start = 1'b1;
    tick;
    start = 1'b0;
    pulse_step;
    chk("step_in_run", int'(bin), 2);
    div = 24'd0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #1 rst = 1'b1;
    #1;
    chk("async_bin", int'(bin), 0);
    chk("async_gray", int'(gray), 0);
    chk("async_run", int'(running), 0);
    chk("async_wrap", int'(wrap), 0);
    tick;
    chk("held_bin", int'(bin), 0);
    chk("held_run", int'(running), 0);
    rst = 1'b0;
    div = 24'd0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 5 == 0) dir = ~dir;
      tick;
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      dir   = 1'($urandom_range(0, 7) == 0 ? ~dir : dir);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      step  = ($urandom_range(0, 3) == 0);
      div   = 24'($urandom_range(0, 5));
      rst   = ($urandom_range(0, 499) == 0);
      tick;
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
